// File: rtl/flag_unit.sv
// Condition-flag holder and condition evaluator between issue and execute.
// Issue stalls while a condition depends on flags that are still in flight.
module flag_unit #(
  parameter int PendDepth = 4,
  parameter int CntWidth  = 3
) (
  input  logic                in_Clk,
  input  logic                in_Rst_n,
  input  logic                in_IssueValid,
  output logic                out_IssueReady,
  input  logic [3:0]          in_IssueCond,
  input  logic                in_IssueSetsFlags,
  output logic                out_ExecValid,
  output logic                out_ExecPass,
  input  logic                in_ExecReady,
  input  logic                in_WbValid,
  input  logic [3:0]          in_WbCNZV,
  input  logic                in_MsrWe,
  input  logic [3:0]          in_MsrCNZV,
  input  logic                in_SaveFlags,
  input  logic                in_RestoreFlags,
  output logic [3:0]          out_CNZV,
  output logic [3:0]          out_SavedCNZV,
  output logic [CntWidth-1:0] out_Pending
);

  localparam logic [3:0]          CondAl   = 4'b1110;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(PendDepth);

  // Flag bit order: [3]=C [2]=N [1]=Z [0]=V.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic c, n, z, v;
    c = f[3];
    n = f[2];
    z = f[1];
    v = f[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  logic [3:0]          cnzv_p1;
  logic [3:0]          saved_p1;
  logic [CntWidth-1:0] pending;
  logic                vld_p1;
  logic                pass_p1;

  logic [3:0]          flag_next_p0;
  logic                wb_dec_p0;
  logic [CntWidth-1:0] pend_eff_p0;
  logic                slot_free_p0;
  logic                dep_ok_p0;
  logic                cap_ok_p0;
  logic                fire_p0;

  // Stage p0: flag forwarding, hazard checks and issue handshake.
  always_comb begin
    flag_next_p0 = cnzv_p1;
    if (in_RestoreFlags)  flag_next_p0 = saved_p1;
    else if (in_MsrWe)    flag_next_p0 = in_MsrCNZV;
    else if (in_WbValid)  flag_next_p0 = in_WbCNZV;
  end

  // A retiring writeback frees its slot in the same cycle, so issue can proceed.
  assign wb_dec_p0    = in_WbValid && (pending != '0);
  assign pend_eff_p0  = pending - CntWidth'(wb_dec_p0);
  assign slot_free_p0 = !vld_p1 || in_ExecReady;
  assign dep_ok_p0    = (in_IssueCond == CondAl) || (pend_eff_p0 == '0);
  assign cap_ok_p0    = !in_IssueSetsFlags || (pend_eff_p0 < DepthCnt);
  assign out_IssueReady = slot_free_p0 && dep_ok_p0 && cap_ok_p0;
  assign fire_p0      = in_IssueValid && out_IssueReady;

  // Stage p1: architectural state and the registered condition result.
  always_ff @(posedge in_Clk or negedge in_Rst_n) begin
    if (!in_Rst_n) begin
      cnzv_p1  <= '0;
      saved_p1 <= '0;
      pending  <= '0;
      vld_p1   <= 1'b0;
      pass_p1  <= 1'b0;
    end else begin
      cnzv_p1 <= flag_next_p0;
      if (in_SaveFlags) saved_p1 <= cnzv_p1;
      pending <= pend_eff_p0 + CntWidth'(fire_p0 && in_IssueSetsFlags);
      if (fire_p0) begin
        vld_p1  <= 1'b1;
        pass_p1 <= cond_pass(in_IssueCond, flag_next_p0);
      end else if (slot_free_p0) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out_CNZV      = cnzv_p1;
  assign out_SavedCNZV = saved_p1;
  assign out_Pending   = pending;
  assign out_ExecValid = vld_p1;
  assign out_ExecPass  = pass_p1;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: condition table, hazards, capacity,
// backpressure, save/restore and asynchronous reset.
module tb_flag_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_ready, issue_sets;
  logic [3:0] issue_cond;
  logic       exec_valid, exec_pass, exec_ready;
  logic       wb_valid, msr_we, save, restore;
  logic [3:0] wb_cnzv, msr_cnzv, cnzv, saved;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_unit #(.PendDepth(4), .CntWidth(3)) dut (
    .in_Clk(clk), .in_Rst_n(rst_n),
    .in_IssueValid(issue_valid), .out_IssueReady(issue_ready),
    .in_IssueCond(issue_cond), .in_IssueSetsFlags(issue_sets),
    .out_ExecValid(exec_valid), .out_ExecPass(exec_pass), .in_ExecReady(exec_ready),
    .in_WbValid(wb_valid), .in_WbCNZV(wb_cnzv),
    .in_MsrWe(msr_we), .in_MsrCNZV(msr_cnzv),
    .in_SaveFlags(save), .in_RestoreFlags(restore),
    .out_CNZV(cnzv), .out_SavedCNZV(saved), .out_Pending(pending)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic msr(input logic [3:0] v);
    msr_we = 1'b1; msr_cnzv = v;
    tick();
    msr_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] cond, input logic sets);
    issue_valid = 1'b1; issue_cond = cond; issue_sets = sets;
    tick();
    issue_valid = 1'b0; issue_sets = 1'b0;
  endtask

  task automatic issue_chk(input string tag, input logic [3:0] cond, input logic exp);
    issue(cond, 1'b0);
    chk({tag, "_vld"}, {7'd0, exec_valid}, 8'd1);
    chk(tag, {7'd0, exec_pass}, {7'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_sets = 1'b0; issue_cond = 4'd0;
    exec_ready = 1'b1; wb_valid = 1'b0; wb_cnzv = 4'd0; msr_we = 1'b0;
    msr_cnzv = 4'd0; save = 1'b0; restore = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_cnzv", {4'd0, cnzv}, 8'h0);
    chk("rst_saved", {4'd0, saved}, 8'h0);
    chk("rst_pending", {5'd0, pending}, 8'h0);
    chk("rst_vld", {7'd0, exec_valid}, 8'h0);
    tick();

    // Condition sweep (bit order C N Z V).
    msr(4'b0010);
    chk("msr_cnzv", {4'd0, cnzv}, 8'h02);
    issue_chk("eq_z1", 4'b0000, 1'b1);
    issue_chk("ne_z1", 4'b0001, 1'b0);
    msr(4'b1000);
    issue_chk("hi_c1", 4'b1000, 1'b1);
    issue_chk("ls_c1", 4'b1001, 1'b0);
    issue_chk("cs_c1", 4'b0010, 1'b1);
    msr(4'b0001);
    issue_chk("ge_v1", 4'b1010, 1'b0);
    issue_chk("lt_v1", 4'b1011, 1'b1);
    issue_chk("gt_v1", 4'b1100, 1'b0);
    issue_chk("le_v1", 4'b1101, 1'b1);
    issue_chk("vs_v1", 4'b0110, 1'b1);
    issue_chk("nv", 4'b1111, 1'b0);
    msr(4'b0100);
    issue_chk("mi_n1", 4'b0100, 1'b1);
    issue_chk("pl_n1", 4'b0101, 1'b0);
    // Forwarding: MSR in the same cycle as issue is seen by the condition.
    msr_we = 1'b1; msr_cnzv = 4'b0010;
    issue_chk("eq_fwd", 4'b0000, 1'b1);
    msr_we = 1'b0;
    tick();
    chk("vld_drop", {7'd0, exec_valid}, 8'd0);

    // Dependency stall.
    msr(4'b0000);
    issue(4'b1110, 1'b1);
    chk("adds_pend", {5'd0, pending}, 8'd1);
    issue_valid = 1'b1; issue_cond = 4'b0000; issue_sets = 1'b0;
    #1 chk("stall_c1", {7'd0, issue_ready}, 8'd0);
    tick();
    chk("stall_c2", {7'd0, issue_ready}, 8'd0);
    tick();
    chk("stall_c3", {7'd0, issue_ready}, 8'd0);
    wb_valid = 1'b1; wb_cnzv = 4'b0010;
    #1 chk("wb_ready", {7'd0, issue_ready}, 8'd1);
    tick();
    wb_valid = 1'b0; issue_valid = 1'b0;
    chk("dep_vld", {7'd0, exec_valid}, 8'd1);
    chk("dep_pass", {7'd0, exec_pass}, 8'd1);
    chk("dep_pend", {5'd0, pending}, 8'd0);
    chk("dep_cnzv", {4'd0, cnzv}, 8'h02);

    // Capacity.
    for (int i = 0; i < 4; i++) issue(4'b1110, 1'b1);
    chk("cap_pend4", {5'd0, pending}, 8'd4);
    issue_valid = 1'b1; issue_cond = 4'b1110; issue_sets = 1'b1;
    #1 chk("cap_block", {7'd0, issue_ready}, 8'd0);
    wb_valid = 1'b1; wb_cnzv = 4'b1000;
    #1 chk("cap_wb_rdy", {7'd0, issue_ready}, 8'd1);
    tick();
    issue_valid = 1'b0; issue_sets = 1'b0; wb_valid = 1'b0;
    chk("cap_pend_hold", {5'd0, pending}, 8'd4);
    chk("cap_vld", {7'd0, exec_valid}, 8'd1);
    chk("cap_cnzv", {4'd0, cnzv}, 8'h08);
    wb_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_pend", {5'd0, pending}, 8'd0);
    wb_cnzv = 4'b0110;
    tick();
    wb_valid = 1'b0;
    chk("wb_err_pend", {5'd0, pending}, 8'd0);
    chk("wb_err_cnzv", {4'd0, cnzv}, 8'h06);

    // Backpressure.
    exec_ready = 1'b0;
    issue(4'b1110, 1'b0);
    chk("bp_vld", {7'd0, exec_valid}, 8'd1);
    issue_valid = 1'b1; issue_cond = 4'b1111;
    #1 chk("bp_rdy0", {7'd0, issue_ready}, 8'd0);
    tick();
    chk("bp_hold_vld", {7'd0, exec_valid}, 8'd1);
    chk("bp_hold_pass", {7'd0, exec_pass}, 8'd1);
    tick();
    chk("bp_hold_pass2", {7'd0, exec_pass}, 8'd1);
    exec_ready = 1'b1;
    #1 chk("bp_rdy1", {7'd0, issue_ready}, 8'd1);
    tick();
    issue_valid = 1'b0;
    chk("bp_new_vld", {7'd0, exec_valid}, 8'd1);
    chk("bp_new_pass", {7'd0, exec_pass}, 8'd0);
    tick();
    chk("bp_empty", {7'd0, exec_valid}, 8'd0);

    // Save / restore.
    msr(4'b1010);
    save = 1'b1;
    tick();
    save = 1'b0;
    chk("save", {4'd0, saved}, 8'h0a);
    msr(4'b0101);
    save = 1'b1; restore = 1'b1;
    tick();
    save = 1'b0; restore = 1'b0;
    chk("swap_cnzv", {4'd0, cnzv}, 8'h0a);
    chk("swap_saved", {4'd0, saved}, 8'h05);
    restore = 1'b1; wb_valid = 1'b1; wb_cnzv = 4'b1111;
    tick();
    restore = 1'b0; wb_valid = 1'b0;
    chk("rst_wins", {4'd0, cnzv}, 8'h05);
    chk("rst_wins_pend", {5'd0, pending}, 8'd0);

    // Asynchronous reset with a held result and a pending writer.
    exec_ready = 1'b0;
    issue(4'b1110, 1'b1);
    chk("pre_rst_vld", {7'd0, exec_valid}, 8'd1);
    chk("pre_rst_pend", {5'd0, pending}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld", {7'd0, exec_valid}, 8'd0);
    chk("async_pass", {7'd0, exec_pass}, 8'd0);
    chk("async_pend", {5'd0, pending}, 8'd0);
    chk("async_cnzv", {4'd0, cnzv}, 8'h0);
    chk("async_saved", {4'd0, saved}, 8'h0);
    rst_n = 1'b1;
    exec_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
